usb_serial_in_ep: RTL and testbench
===================================

// Module: usb_serial_in_ep
// PURPOSE
//  Bulk IN endpoint for a byte stream. Buffers application bytes in a local FIFO and packetises
//  them onto one IN endpoint port of usb_fs_pe (req/grant/data_free/put/data/done/stall/acked).
//  Sends full MAX_PKT packets immediately, flushes short packets after an SOF-counted idle
//  timeout, and appends a ZLP after a final full-size packet. Sits directly downstream of usb_fs_pe.
// PARAMETERS
//  DEPTH         64  FIFO depth in bytes; power of 2, >= MAX_PKT
//  MAX_PKT       32  max bytes per IN packet (8..64)
//  FLUSH_FRAMES  2   SOF pulses of idle before a short packet or ZLP is sent (>= 1)
// PORTS
//  clk              in   1  48 MHz clock, same as usb_fs_pe
//  reset            in   1  synchronous, active-high
//  app_data         in   8  byte from application
//  app_valid        in   1  app_data valid
//  app_ready        out  1  FIFO can accept; write on app_valid && app_ready
//  halt             in   1  endpoint halt request, forwarded to in_ep_stall
//  sof_valid        in   1  one-cycle SOF pulse from usb_fs_pe
//  in_ep_req        out  1  arbitration request to usb_fs_pe
//  in_ep_grant      in   1  arbitration grant
//  in_ep_data_free  in   1  PE packet buffer can take a byte
//  in_ep_data_put   out  1  write in_ep_data into PE buffer this cycle
//  in_ep_data       out  8  byte to PE
//  in_ep_data_done  out  1  one-cycle pulse: packet complete
//  in_ep_stall      out  1  = halt (combinational)
//  in_ep_acked      in   1  one-cycle pulse: host ACKed the packet
// BEHAVIOUR
//  Reset: all outputs 0 except app_ready=1; FIFO empty; state IDLE; frame_cnt=0; zlp_pend=0.
//  Reset mid-packet aborts: FIFO contents discarded, req dropped next cycle, no done pulse.
//  FIFO: wr/rd pointers log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
//   app_ready = (count != DEPTH), combinational. Push+pop same cycle: count unchanged.
//   in_ep_data = mem[rd_ptr], combinational read; meaningful only while in_ep_data_put=1.
//  frame_cnt: cleared on leaving IDLE; in IDLE, +1 per sof_valid if count>0 or zlp_pend;
//   saturates at FLUSH_FRAMES. flush = (frame_cnt == FLUSH_FRAMES).
//  FSM:
//   IDLE:     go ARB if count >= MAX_PKT, or (count>0 && flush), or (zlp_pend && count==0 && flush).
//             A byte arriving while zlp_pend=1 clears zlp_pend (data packet replaces ZLP).
//   ARB:      in_ep_req=1. On in_ep_grant && in_ep_data_free: pkt_len = min(count, MAX_PKT),
//             sent=0; go FILL, or DONE directly if pkt_len==0 (ZLP).
//   FILL:     in_ep_req=1. Each cycle with in_ep_data_free=1: put=1, pop FIFO, sent+1.
//             data_free=0 stalls without put. After the put making sent==pkt_len, go DONE.
//   DONE:     in_ep_req=1, in_ep_data_done=1 for exactly one cycle; go WAIT_ACK.
//   WAIT_ACK: in_ep_req=0. On in_ep_acked: zlp_pend = (pkt_len==MAX_PKT); go IDLE.
//  Bytes written by the app during ARB..WAIT_ACK stay in FIFO for later packets; pkt_len frozen.
//  Put count per packet is exactly pkt_len; no put outside FILL; done never overlaps a put.
//  Losing grant in FILL/DONE (grant=0) is a PE error; block holds state and keeps req=1.
//  halt=1 does not change FSM; the PE returns STALL and no acked arrives, so block waits in WAIT_ACK.
//  Latency: ARB->first put 1 cycle after grant&&free; full packet of N bytes done N+1 cycles later if free=1.
// TESTING
//  1. Write 32 bytes 0x00..0x1F, free=1, grant on req -> 32 puts in order, 1 done, req low in WAIT_ACK.
//  2. Write 5 bytes, no more traffic -> no req until 2nd sof_valid; then 5-byte packet + done.
//  3. Full 32-byte packet then acked, FIFO empty, 2 SOFs -> ARB then done with 0 puts (ZLP).
//  4. Fill to 64 bytes -> app_ready=0 at count 64; two back-to-back 32-byte packets after acks.
//  5. Toggle data_free low for 3 cycles mid-FILL -> no puts during gap, byte order preserved, 32 total.
//  6. Assert reset at 10th put -> next cycle req/put/done=0, app_ready=1, later 1-byte flush works.

Source files
------------

// File: rtl/usb_serial_in_ep.sv
// Bulk IN endpoint: buffers application bytes in a FIFO and packetises them onto one
// usb_fs_pe IN endpoint port, with SOF-timed flushing of short packets and trailing ZLPs.
module usb_serial_in_ep #(
    parameter int DEPTH        = 64,
    parameter int MAX_PKT      = 32,
    parameter int FLUSH_FRAMES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] app_data_i,
    input  logic       app_valid_i,
    output logic       app_ready_o,
    input  logic       halt_i,
    input  logic       sof_valid_i,
    output logic       in_ep_req_o,
    input  logic       in_ep_grant_i,
    input  logic       in_ep_data_free_i,
    output logic       in_ep_data_put_o,
    output logic [7:0] in_ep_data_o,
    output logic       in_ep_data_done_o,
    output logic       in_ep_stall_o,
    input  logic       in_ep_acked_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_PKT + 1);
    localparam int FW = $clog2(FLUSH_FRAMES + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_PKT);
    localparam logic [LW-1:0] LMAX_C  = LW'(MAX_PKT);
    localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_FILL,
        S_DONE,
        S_WAIT_ACK
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            zlp_pend_q, zlp_pend_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d;
    logic [LW-1:0]   sent_q, sent_d;

    logic push;
    logic pop;
    logic flush;

    assign app_ready_o   = (count_q != DEPTH_C);
    assign push          = app_valid_i && app_ready_o;
    assign pop           = in_ep_data_put_o;
    assign flush         = (frame_cnt_q == FLUSH_C);
    assign in_ep_data_o  = mem[rd_ptr_q];
    assign in_ep_stall_o = halt_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // The idle timer only runs while something (data or a pending ZLP) is waiting to go out.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q != S_IDLE) begin
            frame_cnt_d = '0;
        end else if (sof_valid_i && ((count_q != '0) || zlp_pend_q) && !flush) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end
    end

    always_comb begin
        zlp_pend_d = zlp_pend_q;
        if ((state_q == S_WAIT_ACK) && in_ep_acked_i) begin
            zlp_pend_d = (pkt_len_q == LMAX_C);
        end else if (push) begin
            zlp_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d           = state_q;
        pkt_len_d         = pkt_len_q;
        sent_d            = sent_q;
        in_ep_req_o       = 1'b0;
        in_ep_data_put_o  = 1'b0;
        in_ep_data_done_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q >= MAX_C) || ((count_q != '0) && flush) ||
                    (zlp_pend_q && (count_q == '0) && flush)) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                in_ep_req_o = 1'b1;
                if (in_ep_grant_i && in_ep_data_free_i) begin
                    pkt_len_d = (count_q >= MAX_C) ? LMAX_C : LW'(count_q);
                    sent_d    = '0;
                    state_d   = (count_q == '0) ? S_DONE : S_FILL;
                end
            end
            // A missing grant here is a PE fault; hold everything and keep requesting.
            S_FILL: begin
                in_ep_req_o = 1'b1;
                if (in_ep_grant_i && in_ep_data_free_i) begin
                    in_ep_data_put_o = 1'b1;
                    sent_d           = sent_q + LW'(1);
                    if ((sent_q + LW'(1)) == pkt_len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                in_ep_req_o = 1'b1;
                if (in_ep_grant_i) begin
                    in_ep_data_done_o = 1'b1;
                    state_d           = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (in_ep_acked_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            zlp_pend_q  <= 1'b0;
            pkt_len_q   <= '0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
            zlp_pend_q  <= zlp_pend_d;
            pkt_len_q   <= pkt_len_d;
            sent_q      <= sent_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= app_data_i;
        end
    end

endmodule

// File: tb/tb_usb_serial_in_ep.sv
// Directed bench for usb_serial_in_ep: a scoreboard queue of written bytes is checked
// against every put, with a simple PE model granting whenever the endpoint requests.
module tb_usb_serial_in_ep;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] appData;
    logic       appValid;
    logic       appReady;
    logic       halt;
    logic       sof;
    logic       inEpReq;
    logic       inEpGrant;
    logic       grantEn;
    logic       dataFree;
    logic       inEpDataPut;
    logic [7:0] inEpData;
    logic       inEpDataDone;
    logic       inEpStall;
    logic       acked;

    int total = 0;
    int bad = 0;
    int putTotal = 0;
    int pktPuts = 0;
    int lastPktLen = -1;
    int doneCount = 0;
    logic [7:0] expQ[$];

    usb_serial_in_ep #(.DEPTH(64), .MAX_PKT(32), .FLUSH_FRAMES(2)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .app_data_i        (appData),
        .app_valid_i       (appValid),
        .app_ready_o       (appReady),
        .halt_i            (halt),
        .sof_valid_i       (sof),
        .in_ep_req_o       (inEpReq),
        .in_ep_grant_i     (inEpGrant),
        .in_ep_data_free_i (dataFree),
        .in_ep_data_put_o  (inEpDataPut),
        .in_ep_data_o      (inEpData),
        .in_ep_data_done_o (inEpDataDone),
        .in_ep_stall_o     (inEpStall),
        .in_ep_acked_i     (acked)
    );

    assign inEpGrant = inEpReq && grantEn;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every put must be gated by free/grant and match the oldest written byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (inEpDataPut) begin
                putTotal++;
                pktPuts++;
                checkOutput("put_gated", {31'd0, dataFree && inEpGrant}, 32'd1);
                checkOutput("put_expected", {31'd0, expQ.size() != 0}, 32'd1);
                if (expQ.size() != 0) begin
                    checkOutput("put_data", {24'd0, inEpData}, {24'd0, expQ.pop_front()});
                end
            end
            if (inEpDataDone) begin
                checkOutput("done_no_put", {31'd0, inEpDataPut}, 32'd0);
                lastPktLen = pktPuts;
                pktPuts = 0;
                doneCount++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] startVal, input int n);
        int waitCycles;
        for (int i = 0; i < n; i++) begin
            appData = startVal + 8'(i);
            appValid = 1'b1;
            waitCycles = 0;
            @(negedge clk);
            while (!appReady && waitCycles < 300) begin
                @(negedge clk);
                waitCycles++;
            end
            checkOutput("write_ready", {31'd0, appReady}, 32'd1);
            if (appReady) expQ.push_back(appData);
            @(posedge clk);
            #1;
        end
        appValid = 1'b0;
    endtask

    task automatic pulseSof();
        sof = 1'b1;
        @(posedge clk);
        #1;
        sof = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int d0;
        int n;
        d0 = doneCount;
        n = 0;
        while (doneCount == d0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("done_seen", {31'd0, doneCount != d0}, 32'd1);
    endtask

    task automatic sendAck();
        acked = 1'b1;
        @(posedge clk);
        #1;
        acked = 1'b0;
    endtask

    task automatic checkReqLow(input string tag);
        @(negedge clk);
        checkOutput(tag, {31'd0, inEpReq}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int p0;
        int n;
        int k;
        reset = 1'b1;
        appData = 8'h00;
        appValid = 1'b0;
        halt = 1'b0;
        sof = 1'b0;
        grantEn = 1'b1;
        dataFree = 1'b1;
        acked = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", {31'd0, inEpReq}, 32'd0);
        checkOutput("rst_put", {31'd0, inEpDataPut}, 32'd0);
        checkOutput("rst_done", {31'd0, inEpDataDone}, 32'd0);
        checkOutput("rst_ready", {31'd0, appReady}, 32'd1);
        checkOutput("rst_stall", {31'd0, inEpStall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        halt = 1'b1;
        @(negedge clk);
        checkOutput("halt_stall", {31'd0, inEpStall}, 32'd1);
        @(posedge clk);
        #1;
        halt = 1'b0;

        $display("[TB] full packet of 32 bytes followed by a ZLP");
        applyStimulus(8'h00, 32);
        waitDone(200);
        checkOutput("t1_len", lastPktLen, 32);
        checkReqLow("t1_req_wait_ack");
        sendAck();
        idle(4);
        pulseSof();
        idle(5);
        checkReqLow("t3_no_zlp_one_sof");
        pulseSof();
        waitDone(50);
        checkOutput("t3_zlp_len", lastPktLen, 0);
        sendAck();

        $display("[TB] short packet flushed by SOF timeout");
        applyStimulus(8'hA0, 5);
        idle(10);
        checkReqLow("t2_no_req_before_sof");
        pulseSof();
        idle(5);
        checkReqLow("t2_no_req_one_sof");
        pulseSof();
        waitDone(50);
        checkOutput("t2_len", lastPktLen, 5);
        sendAck();
        d0 = doneCount;
        repeat (3) begin
            pulseSof();
            idle(3);
        end
        checkOutput("t2_no_zlp_after_short", doneCount, d0);
        checkReqLow("t2_idle_req");

        $display("[TB] fill FIFO to 64 then drain two packets");
        grantEn = 1'b0;
        applyStimulus(8'h10, 64);
        @(negedge clk);
        checkOutput("t4_full_ready", {31'd0, appReady}, 32'd0);
        checkOutput("t4_req_pending", {31'd0, inEpReq}, 32'd1);
        @(posedge clk);
        #1;
        appData = 8'hEE;
        appValid = 1'b1;
        @(posedge clk);
        #1;
        appValid = 1'b0;
        grantEn = 1'b1;
        waitDone(200);
        checkOutput("t4_len_a", lastPktLen, 32);
        @(negedge clk);
        checkOutput("t4_ready_after_drain", {31'd0, appReady}, 32'd1);
        @(posedge clk);
        #1;
        sendAck();
        waitDone(200);
        checkOutput("t4_len_b", lastPktLen, 32);
        sendAck();

        $display("[TB] data_free gap in the middle of a packet");
        applyStimulus(8'h40, 32);
        n = 0;
        while (pktPuts < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5_reached_gap", {31'd0, pktPuts >= 10}, 32'd1);
        dataFree = 1'b0;
        p0 = putTotal;
        idle(3);
        checkOutput("t5_no_put_in_gap", putTotal - p0, 0);
        dataFree = 1'b1;
        waitDone(200);
        checkOutput("t5_len", lastPktLen, 32);
        sendAck();

        $display("[TB] reset in the middle of a packet");
        applyStimulus(8'h80, 32);
        n = 0;
        k = 0;
        while (n < 10 && k < 300) begin
            @(negedge clk);
            k++;
            if (inEpDataPut) n++;
        end
        checkOutput("t6_tenth_put", n, 10);
        reset = 1'b1;
        expQ.delete();
        pktPuts = 0;
        d0 = doneCount;
        @(negedge clk);
        checkOutput("t6_req", {31'd0, inEpReq}, 32'd0);
        checkOutput("t6_put", {31'd0, inEpDataPut}, 32'd0);
        checkOutput("t6_done", {31'd0, inEpDataDone}, 32'd0);
        checkOutput("t6_ready", {31'd0, appReady}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10);
        checkReqLow("t6_empty_after_reset");
        checkOutput("t6_no_done", doneCount, d0);
        applyStimulus(8'hC5, 1);
        pulseSof();
        idle(2);
        pulseSof();
        waitDone(50);
        checkOutput("t6_len", lastPktLen, 1);
        sendAck();

        idle(5);
        checkOutput("scoreboard_empty", expQ.size(), 0);
        checkOutput("done_total", doneCount, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
